mod_demux: RTL and testbench
============================

// Module: mod_demux
// PURPOSE
//  Registered 1-to-8 demultiplexer: the distribution-side counterpart of the 8:1 word mux.
//  Routes one W-bit input word per accepted transfer to one of eight output channels, selected by S2..S0.
//  Each channel has a one-entry holding register with its own valid/ready handshake.
//  Sits between a single producer and eight independent consumers.
// PARAMETERS
//  W      3   data width per word/channel
//  CNT_W  16  width of accepted-word counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  D          in   W      input data word
//  S2,S1,S0   in   1 ea   channel select; {S2,S1,S0} = channel index 0..7
//  in_valid   in   1      producer presents D/S
//  in_ready   out  1      block can accept this cycle (combinational)
//  Y          out  8*W    channel data; Y[i*W +: W] = channel i
//  out_valid  out  8      channel i holds a word
//  out_ready  in   8      consumer i takes word this cycle
//  acc_cnt    out  CNT_W  count of accepted input words
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - Reset: out_valid=0, Y=0, acc_cnt=0. in_ready follows the rule below, so it reads 1 after reset.
//  - Reset asserted mid-transfer: held words are discarded and no partial state survives.
//  - sel={S2,S1,S0}. in_ready = ~out_valid[sel] | out_ready[sel].
//  - accept = in_valid & in_ready. There is no dependency from in_valid to in_ready.
//  - Per channel i, each clock:
//      accept & sel==i          -> Y_i<=D, out_valid[i]<=1
//      else out_ready[i]        -> out_valid[i]<=0, Y_i holds
//      else                     -> hold
//  - Simultaneous drain and load on the same channel: the old word leaves, the new word loads, valid stays 1.
//    Full throughput is 1 word/cycle.
//  - Latency: 1 cycle from accept to out_valid.
//  - Y_i is stable while out_valid[i]=1 && !out_ready[i].
//  - out_ready[i] with out_valid[i]=0 is ignored.
//  - Channels are independent. A stalled channel never blocks a different sel.
//  - acc_cnt increments by 1 per accept and wraps modulo 2^CNT_W with no saturation.
//  - An X/Z select is treated as channel 0. This mirrors the mux default arm.
// CONFIGURATION
//  Macro MOD_DEMUX_BCAST_EN.
//  - Defined: adds input port bcast (1 bit).
//    While bcast=1, sel is ignored and in_ready = AND over i of (~out_valid[i] | out_ready[i]).
//    On accept, all 8 channels load D and set out_valid. acc_cnt still increments by 1.
//  - Undefined: the bcast port is absent and only unicast routing exists. Behaviour is otherwise identical.
// STRUCTURE
//  - Shared package/include (mod_mux_pkg): NUM_CH=8, SEL_W=3, default W.
//    The mux uses the same constants.
//  - Sub-module demux_slot: one-entry register with valid/ready, load and drain logic.
//    Instantiated 8x via generate.
//  - Top level holds sel decode, in_ready mux, counter and the bcast option.
// TESTING
//  1 Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, Y=0, acc_cnt=0 immediately; in_ready=1.
//  2 Unicast: D=3'b101, sel=6, in_valid=1 for one cycle -> next cycle out_valid=8'b0100_0000,
//    Y[18+:3]=3'b101, acc_cnt=1.
//  3 Backpressure: ch2 full with out_ready[2]=0 and sel=2 -> in_ready=0, no load, Y[6+:3] stable.
//    Switch sel to 5 -> in_ready=1 and the word is accepted into ch5.
//  4 Pass-through: ch3 full, out_ready[3]=1, new D=3'b011 to sel=3 -> ch3 reloads, out_valid[3] stays 1,
//    and 8 back-to-back words are accepted in 8 cycles.
//  5 Wrap: preload acc_cnt to 16'hFFFF via 65535 accepts, then one more accept -> acc_cnt=0.
//  6 BCAST_EN: bcast=1, D=3'b111, all slots empty -> all 8 channels hold 3'b111 and acc_cnt +1.
//    With ch0 full and stalled, in_ready=0.

Source files
------------

// File: rtl/mod_demux_pkg.sv
// Constants shared by the 8:1 word mux and the 1:8 demux, plus the select-folding helper.
// MOD_DEMUX_BCAST_EN (optional) adds a broadcast input port to mod_demux.
package mod_demux_pkg;

    localparam int NUM_CH    = 8;
    localparam int SEL_W     = 3;
    localparam int DEF_W     = 3;
    localparam int DEF_CNT_W = 16;

    // Any select value that is not a clean 0..7 routes to channel 0, matching the mux default arm.
    function automatic logic [SEL_W-1:0] sel_fold(input logic [SEL_W-1:0] s);
        logic [SEL_W-1:0] r;
        case (s)
            3'd0: r = 3'd0;
            3'd1: r = 3'd1;
            3'd2: r = 3'd2;
            3'd3: r = 3'd3;
            3'd4: r = 3'd4;
            3'd5: r = 3'd5;
            3'd6: r = 3'd6;
            3'd7: r = 3'd7;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mod_demux_if.sv
// Producer-side and consumer-side handshake bundle for mod_demux.
// master drives D/S/in_valid/out_ready; slave (the demux) drives in_ready/Y/out_valid.
interface mod_demux_if #(
    parameter int W = 3
);
    import mod_demux_pkg::*;

    logic [W-1:0]        D;
    logic                S2;
    logic                S1;
    logic                S0;
    logic                in_valid;
    logic                in_ready;
    logic [NUM_CH*W-1:0] Y;
    logic [NUM_CH-1:0]   out_valid;
    logic [NUM_CH-1:0]   out_ready;

    modport master (
        output D, S2, S1, S0, in_valid, out_ready,
        input  in_ready, Y, out_valid
    );

    modport slave (
        input  D, S2, S1, S0, in_valid, out_ready,
        output in_ready, Y, out_valid
    );

endinterface

// File: rtl/mod_demux_slot.sv
// One-entry channel holding register: load wins over drain, so load+drain keeps valid high.
// Latency 1 cycle load->vld; dat is frozen whenever no load occurs.
module mod_demux_slot #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= d;
        end else if (drain) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/mod_demux.sv
// Registered 1-to-8 demux: one word per accept routed to channel {S2,S1,S0}, 1-cycle latency.
// in_ready is combinational from the selected slot only, so a stalled channel never blocks others.
// MOD_DEMUX_BCAST_EN adds port bcast, which loads all eight slots and needs all of them free.
module mod_demux
    import mod_demux_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MOD_DEMUX_BCAST_EN
    input  logic             bcast,
`endif
    mod_demux_if.slave       bus,
    output logic [CNT_W-1:0] acc_cnt
);

    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] slot_vld;
    logic [NUM_CH-1:0] slot_free;
    logic [NUM_CH-1:0] load;
    logic              bc;
    logic              accept;

`ifdef MOD_DEMUX_BCAST_EN
    assign bc = bcast;
`else
    assign bc = 1'b0;
`endif

    assign sel       = sel_fold({bus.S2, bus.S1, bus.S0});
    // A slot can take a word if it is empty or is being emptied this same cycle.
    assign slot_free = ~slot_vld | bus.out_ready;

    assign bus.in_ready  = bc ? (&slot_free) : slot_free[sel];
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = slot_vld;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        assign load[i] = accept & (bc | (sel == SEL_W'(i)));

        mod_demux_slot #(
            .W (W)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .drain (bus.out_ready[i]),
            .d     (bus.D),
            .vld   (slot_vld[i]),
            .dat   (bus.Y[i*W +: W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mod_demux.sv
module tb_mod_demux;
    import mod_demux_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] acc_cnt;
`ifdef MOD_DEMUX_BCAST_EN
    logic        bcast = 1'b0;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [2:0] q [8][$];

    always #5 clk = ~clk;

    mod_demux_if #(.W(3)) bus ();

    mod_demux #(.W(3), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef MOD_DEMUX_BCAST_EN
        .bcast   (bcast),
`endif
        .bus     (bus),
        .acc_cnt (acc_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int q_total();
        int n = 0;
        for (int i = 0; i < 8; i++) n += q[i].size();
        return n;
    endfunction

    task automatic q_clear();
        for (int i = 0; i < 8; i++) q[i].delete();
    endtask

    // Present one word for one cycle; exp_rdy is the hand-derived in_ready for this cycle.
    task automatic xfer(input int ch, input logic [2:0] d, input logic exp_rdy);
        logic [2:0] s;
        s = ch[2:0];
        {bus.S2, bus.S1, bus.S0} = s;
        bus.D        = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        if (exp_rdy) q[ch].push_back(d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: every handshake on an output channel must match the oldest queued word.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL drain_ch%0d: got word %0h expected no word", i, bus.Y[i*3 +: 3]);
                    end else begin
                        logic [2:0] e;
                        e = q[i].pop_front();
                        chk($sformatf("drain_ch%0d", i), {29'b0, bus.Y[i*3 +: 3]}, {29'b0, e});
                    end
                end
            end
        end
    end

    initial begin
        bus.D = '0;
        {bus.S2, bus.S1, bus.S0} = 3'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Async reset in the middle of a cycle with a word held
        xfer(1, 3'b110, 1'b1);
        chk("pre_rst_vld", {24'b0, bus.out_valid}, 32'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld", {24'b0, bus.out_valid}, 32'h0);
        chk("rst_y", {8'b0, bus.Y}, 32'h0);
        chk("rst_cnt", {16'b0, acc_cnt}, 32'h0);
        chk("rst_rdy", {31'b0, bus.in_ready}, 32'h1);
        q_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Unicast to channel 6
        xfer(6, 3'b101, 1'b1);
        chk("uni_vld", {24'b0, bus.out_valid}, 32'h40);
        chk("uni_y6", {29'b0, bus.Y[18 +: 3]}, 32'h5);
        chk("uni_cnt", {16'b0, acc_cnt}, 32'h1);

        // Backpressure on channel 2, then redirect to channel 5
        xfer(2, 3'b010, 1'b1);
        {bus.S2, bus.S1, bus.S0} = 3'd2;
        bus.D        = 3'b111;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("bp_rdy", {31'b0, bus.in_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("bp_y2", {29'b0, bus.Y[6 +: 3]}, 32'h2);
        chk("bp_cnt", {16'b0, acc_cnt}, 32'h2);
        chk("bp_vld", {24'b0, bus.out_valid}, 32'h44);
        xfer(5, 3'b111, 1'b1);
        chk("redir_vld", {24'b0, bus.out_valid}, 32'h64);
        chk("redir_cnt", {16'b0, acc_cnt}, 32'h3);

        // Pass-through on channel 3: drain and reload in the same cycle
        xfer(3, 3'b001, 1'b1);
        bus.out_ready = 8'h08;
        xfer(3, 3'b011, 1'b1);
        chk("pt_vld3", {31'b0, bus.out_valid[3]}, 32'h1);
        chk("pt_y3", {29'b0, bus.Y[9 +: 3]}, 32'h3);
        for (int k = 0; k < 8; k++) begin
            logic [2:0] d;
            d = 3'(k);
            {bus.S2, bus.S1, bus.S0} = 3'd3;
            bus.D        = d;
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("b2b_rdy", {31'b0, bus.in_ready}, 32'h1);
            q[3].push_back(d);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("b2b_cnt", {16'b0, acc_cnt}, 32'd13);
        chk("b2b_vld3", {31'b0, bus.out_valid[3]}, 32'h1);
        bus.out_ready = 8'hFF;
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 8'h00;
        chk("drain_vld", {24'b0, bus.out_valid}, 32'h0);
        chk("drain_q", q_total(), 0);

        // Counter wrap after 65536 accepts, all channels draining continuously
        rst_n = 1'b0;
        #1 q_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 8'hFF;
        for (int i = 0; i < 65535; i++) xfer(i % 8, 3'(i), 1'b1);
        chk("wrap_pre", {16'b0, acc_cnt}, 32'hFFFF);
        xfer(0, 3'b100, 1'b1);
        chk("wrap_cnt", {16'b0, acc_cnt}, 32'h0);
        @(posedge clk);
        #1 bus.out_ready = 8'h00;
        chk("wrap_vld", {24'b0, bus.out_valid}, 32'h0);
        chk("wrap_q", q_total(), 0);

`ifdef MOD_DEMUX_BCAST_EN
        // Broadcast into empty slots, then a stalled channel 0 blocks broadcast
        bcast = 1'b1;
        {bus.S2, bus.S1, bus.S0} = 3'd4;
        bus.D        = 3'b111;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("bc_rdy", {31'b0, bus.in_ready}, 32'h1);
        for (int i = 0; i < 8; i++) q[i].push_back(3'b111);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("bc_vld", {24'b0, bus.out_valid}, 32'hFF);
        chk("bc_y", {8'b0, bus.Y}, 32'hFFFFFF);
        chk("bc_cnt", {16'b0, acc_cnt}, 32'h1);
        bus.D         = 3'b010;
        bus.out_ready = 8'hFE;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        chk("bc_stall_rdy", {31'b0, bus.in_ready}, 32'h0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("bc_stall_vld", {24'b0, bus.out_valid}, 32'h01);
        bus.out_ready = 8'hFF;
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 8'h00;
        bcast = 1'b0;
        chk("bc_cnt2", {16'b0, acc_cnt}, 32'h1);
`endif

        chk("end_vld", {24'b0, bus.out_valid}, 32'h0);
        chk("end_q", q_total(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
